// File: rtl/button_debouncer.sv
// ============================================================================
// button_debouncer: sampled debounce with press/release/auto-repeat pulses
// Revision 1.0
// ============================================================================
`default_nettype none

module button_debouncer #(
    parameter int N_BTN        = 3,
    parameter int STABLE_TICKS = 4,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_src,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    localparam int CNT_W  = $clog2(STABLE_TICKS + 1);
    localparam int RMAX   = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCNT_W = $clog2(RMAX + 1);

    localparam logic [CNT_W-1:0]  C_CNT_LAST   = CNT_W'(STABLE_TICKS - 1);
    localparam logic [RCNT_W-1:0] C_DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] C_RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } rep_state_t;

    // [0],[1] synchronizer stages, [2] edge-detect history
    logic [2:0]       tick_sync;
    logic             sample_tick;
    logic [N_BTN-1:0] btn_meta;
    logic [N_BTN-1:0] btn_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_sync <= '0;
            btn_meta  <= '0;
            btn_sync  <= '0;
        end else begin
            tick_sync <= {tick_sync[1:0], tick_src};
            btn_meta  <= btn_raw;
            btn_sync  <= btn_meta;
        end
    end

    assign sample_tick = tick_sync[1] & ~tick_sync[2];

    generate
        for (genvar i = 0; i < N_BTN; i++) begin : g_chan
            logic [CNT_W-1:0]  cnt;
            logic              level;
            logic              press;
            logic              rel;
            logic              rep;
            logic              rep_nx;
            logic              differ;
            logic              accept;
            logic              acc_press;
            logic              acc_release;
            rep_state_t        state;
            rep_state_t        state_nx;
            logic [RCNT_W-1:0] rcnt;
            logic [RCNT_W-1:0] rcnt_nx;

            assign differ      = btn_sync[i] ^ level;
            assign accept      = sample_tick & differ & (cnt == C_CNT_LAST);
            assign acc_press   = accept & btn_sync[i];
            assign acc_release = accept & ~btn_sync[i];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt   <= '0;
                    level <= 1'b0;
                    press <= 1'b0;
                    rel   <= 1'b0;
                end else begin
                    press <= acc_press;
                    rel   <= acc_release;
                    if (sample_tick) begin
                        if (!differ) begin
                            cnt <= '0;
                        end else if (cnt == C_CNT_LAST) begin
                            level <= btn_sync[i];
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
            end

            // A release always wins over a repeat due on the same tick. With
            // repeat disabled at the end of DELAY the count parks, so the first
            // repeat fires on the first enabled tick.
            always_comb begin
                state_nx = state;
                rcnt_nx  = rcnt;
                rep_nx   = 1'b0;
                case (state)
                    S_IDLE: begin
                        if (acc_press) begin
                            state_nx = S_DELAY;
                            rcnt_nx  = '0;
                        end
                    end
                    S_DELAY: begin
                        if (acc_release) begin
                            state_nx = S_IDLE;
                            rcnt_nx  = '0;
                        end else if (sample_tick) begin
                            if (rcnt == C_DELAY_LAST) begin
                                if (repeat_en[i]) begin
                                    rep_nx   = 1'b1;
                                    state_nx = S_REPEAT;
                                    rcnt_nx  = '0;
                                end
                            end else begin
                                rcnt_nx = rcnt + 1'b1;
                            end
                        end
                    end
                    S_REPEAT: begin
                        if (acc_release) begin
                            state_nx = S_IDLE;
                            rcnt_nx  = '0;
                        end else if (sample_tick) begin
                            if (rcnt == C_RATE_LAST) begin
                                rep_nx  = repeat_en[i];
                                rcnt_nx = '0;
                            end else begin
                                rcnt_nx = rcnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_nx = S_IDLE;
                        rcnt_nx  = '0;
                    end
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state <= S_IDLE;
                    rcnt  <= '0;
                    rep   <= 1'b0;
                end else begin
                    state <= state_nx;
                    rcnt  <= rcnt_nx;
                    rep   <= rep_nx;
                end
            end

            assign btn_level[i]   = level;
            assign btn_press[i]   = press;
            assign btn_release[i] = rel;
            assign btn_repeat[i]  = rep;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_button_debouncer.sv
// ============================================================================
// tb_button_debouncer: scoreboard bench with a tick-level behavioural model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_button_debouncer;

    localparam int STABLE = 4;
    localparam int RD     = 32;
    localparam int RATE   = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_src;
    logic [2:0] btn_raw;
    logic [2:0] repeat_en;
    logic [2:0] btn_level;
    logic [2:0] btn_press;
    logic [2:0] btn_release;
    logic [2:0] btn_repeat;

    button_debouncer #(
        .N_BTN(3), .STABLE_TICKS(STABLE), .REPEAT_DELAY(RD), .REPEAT_RATE(RATE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick_src(tick_src), .btn_raw(btn_raw),
        .repeat_en(repeat_en), .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_repeat(btn_repeat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [2:0] press;
        logic [2:0] rel;
        logic [2:0] rep;
        logic [2:0] level;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors    = 0;
    int   miscompares = 0;
    int   rep2_seen  = 0;

    // Model state: level, consecutive differing samples, ticks since press
    logic [2:0] m_level;
    int         m_cnt[3];
    int         m_k[3];
    bit         m_started[3];
    int         m_due[3];

    task automatic model_reset();
        m_level = 3'b000;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0; m_k[i] = 0; m_started[i] = 0; m_due[i] = 0;
        end
    endtask

    task automatic model_tick(input logic [2:0] raw, input logic [2:0] en, input int c);
        exp_t e;
        e.cyc = c + 3; e.press = '0; e.rel = '0; e.rep = '0;
        for (int i = 0; i < 3; i++) begin
            bit held;
            bit accept;
            held   = m_level[i];
            accept = 0;
            if (raw[i] != m_level[i]) begin
                m_cnt[i]++;
                if (m_cnt[i] == STABLE) begin
                    accept = 1; m_cnt[i] = 0; m_level[i] = raw[i];
                end
            end else begin
                m_cnt[i] = 0;
            end
            if (accept && raw[i]) begin
                e.press[i] = 1'b1; m_k[i] = 0; m_started[i] = 0;
            end else if (accept) begin
                e.rel[i] = 1'b1;
            end else if (held) begin
                m_k[i]++;
                if (!m_started[i]) begin
                    if (m_k[i] >= RD && en[i]) begin
                        e.rep[i] = 1'b1; m_started[i] = 1; m_due[i] = m_k[i] + RATE;
                    end
                end else if (m_k[i] == m_due[i]) begin
                    if (en[i]) e.rep[i] = 1'b1;
                    m_due[i] += RATE;
                end
            end
        end
        e.level = m_level;
        if ((e.press | e.rel | e.rep) != 3'b000) sb_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    // One tick_src period of 8 clk; inputs change only while tick_src is low
    task automatic do_tick(input logic [2:0] raw, input logic [2:0] en);
        btn_raw   = raw;
        repeat_en = en;
        repeat (4) @(negedge clk);
        tick_src = 1'b1;
        model_tick(raw, en, cyc);
        repeat (4) @(negedge clk);
        tick_src = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && (btn_press | btn_release | btn_repeat) != 3'b000) begin
            if (btn_repeat[2]) rep2_seen++;
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b repeat=%b required=none",
                         cyc, btn_press, btn_release, btn_repeat);
            end else begin
                mon_e = sb_q.pop_front();
                if (cyc != mon_e.cyc || btn_press !== mon_e.press || btn_release !== mon_e.rel ||
                    btn_repeat !== mon_e.rep || btn_level !== mon_e.level) begin
                    miscompares++;
                    $display("FAIL pulse got cyc=%0d p=%b r=%b rep=%b lvl=%b required cyc=%0d p=%b r=%b rep=%b lvl=%b",
                             cyc, btn_press, btn_release, btn_repeat, btn_level,
                             mon_e.cyc, mon_e.press, mon_e.rel, mon_e.rep, mon_e.level);
                end
            end
        end
    end

    function automatic logic [11:0] outs();
        return {btn_level, btn_press, btn_release, btn_repeat};
    endfunction

    logic [2:0] raw_r;
    logic [2:0] en_r;
    int         flip_max;

    initial begin
        model_reset();
        rst_n = 1'b0; tick_src = 1'b0; btn_raw = 3'b111; repeat_en = 3'b000;
        repeat (4) begin
            repeat (3) @(negedge clk);
            tick_src = ~tick_src;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_outputs", 32'(outs()), 32'h0);
        end
        rst_n = 1'b1;
        btn_raw = 3'b001;

        repeat (4) do_tick(3'b001, 3'b000);
        check("first_press_level", 32'(btn_level), 32'h1);

        repeat (3) do_tick(3'b011, 3'b000);
        repeat (2) do_tick(3'b001, 3'b000);
        check("glitch_rejected", 32'(btn_level), 32'h1);
        repeat (4) do_tick(3'b011, 3'b000);
        check("glitch_then_press", 32'(btn_level), 32'h3);

        repeat (4) do_tick(3'b000, 3'b000);
        check("release_level", 32'(btn_level), 32'h0);

        rep2_seen = 0;
        repeat (68) do_tick(3'b100, 3'b111);
        check("repeat_count_64", 32'(rep2_seen), 32'd5);
        repeat (4) do_tick(3'b100, 3'b111);
        repeat (4) do_tick(3'b000, 3'b111);
        check("release_beats_repeat", 32'(rep2_seen), 32'd5);
        check("release_beats_level", 32'(btn_level), 32'h0);

        repeat (44) do_tick(3'b100, 3'b111);
        rep2_seen = 0;
        repeat (20) do_tick(3'b100, 3'b011);
        check("repeat_gated", 32'(rep2_seen), 32'd0);
        rep2_seen = 0;
        repeat (20) do_tick(3'b100, 3'b111);
        check("repeat_resumed", 32'(rep2_seen), 32'd3);
        repeat (4) do_tick(3'b000, 3'b111);

        repeat (4) do_tick(3'b011, 3'b000);
        check("concurrent_press", 32'(btn_level), 32'h3);

        for (int i = 0; i < 1000; i++) begin
            if (i % 50 == 0) btn_raw = 3'($urandom_range(0, 7));
            @(negedge clk);
        end
        check("stall_level_frozen", 32'(btn_level), 32'h3);

        do_tick(3'b011, 3'b000);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midpress_reset", 32'(outs()), 32'h0);
        rst_n = 1'b1;
        model_reset();
        repeat (4) do_tick(3'b011, 3'b000);
        check("repress_after_reset", 32'(btn_level), 32'h3);

        raw_r = 3'b011; en_r = 3'b111; flip_max = 3;
        for (int t = 0; t < 400; t++) begin
            if (t % 50 == 0) flip_max = ($urandom_range(0, 1) == 0) ? 3 : 40;
            for (int b = 0; b < 3; b++)
                if ($urandom_range(0, flip_max - 1) == 0) raw_r[b] = ~raw_r[b];
            if ($urandom_range(0, 15) == 0) en_r = 3'($urandom_range(0, 7));
            do_tick(raw_r, en_r);
        end
        check("random_level", 32'(btn_level), 32'(m_level));

        repeat (10) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
